// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared core definitions for the hazard scoreboard: register/data widths and MDU countdown states.
package hazard_scoreboard_unit_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int MDU_LAT_W = 6;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // A zero latency still occupies HI/LO for one cycle.
  function automatic logic [MDU_LAT_W-1:0] mdu_lat_load(input logic [MDU_LAT_W-1:0] lat);
    return (lat == '0) ? MDU_LAT_W'(1) : lat;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_unit_fwd_port_sel.sv
// One ID read port: youngest-first operand forwarding and load-use hazard detection.
module fwd_port_sel
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic                      rd_use,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_clean,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      hazard
);
  logic hit;
  logic hit_clean;

  // Walk oldest to youngest so the lowest-index match is the last write and wins.
  always_comb begin
    rd_data   = rf_data;
    hit       = 1'b0;
    hit_clean = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
        rd_data   = fwd_data[i*DATA_W +: DATA_W];
        hit       = 1'b1;
        hit_clean = fwd_clean[i];
      end
    end
  end

  assign hazard = rd_use && (rd_addr != '0) && hit && !hit_clean;
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard scoreboard: forwarding, load-use and HI/LO stalls, MDU countdown.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
//
// state    | meaning
// MDU_IDLE | no HI/LO result outstanding
// MDU_BUSY | multiply/divide in flight, mdu_cnt cycles until HI/LO is written
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD-1:0]         id_rd_use,
  input  logic [NUM_RD*ADDR_W-1:0]  id_rd_addr,
  input  logic [NUM_RD*DATA_W-1:0]  wb_rd_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_clean,
  input  logic                      id_use_hilo,
  input  logic                      mdu_start,
  input  logic [MDU_LAT_W-1:0]      mdu_lat,
  input  logic                      flush,
  output logic [NUM_RD*DATA_W-1:0]  rd_data_latest,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_clr,
  output logic                      mdu_busy,
  output logic [CNT_W-1:0]          stall_cnt
);
  logic [NUM_RD-1:0]    reg_haz;
  logic                 hilo_haz;
  logic                 stall;
  mdu_state_t           mdu_state;
  logic [MDU_LAT_W-1:0] mdu_cnt;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_sel #(.NUM_FWD(NUM_FWD)) u_fwd_port_sel (
      .rd_use    (id_rd_use[p]),
      .rd_addr   (id_rd_addr[p*ADDR_W +: ADDR_W]),
      .rf_data   (wb_rd_data[p*DATA_W +: DATA_W]),
      .fwd_we    (fwd_we),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .fwd_clean (fwd_clean),
      .rd_data   (rd_data_latest[p*DATA_W +: DATA_W]),
      .hazard    (reg_haz[p])
    );
  end

  assign hilo_haz  = id_use_hilo && (mdu_busy || mdu_start);
  assign stall     = ((|reg_haz) || hilo_haz) && !flush;
  assign pc_en     = !stall;
  assign if_id_en  = !stall;
  assign id_ex_clr = stall || flush;
  assign mdu_busy  = (mdu_state == MDU_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_state <= MDU_IDLE;
      mdu_cnt   <= '0;
    end else if (flush) begin
      mdu_state <= MDU_IDLE;
      mdu_cnt   <= '0;
    end else if (mdu_start) begin
      mdu_state <= MDU_BUSY;
      mdu_cnt   <= mdu_lat_load(mdu_lat);
    end else begin
      case (mdu_state)
        MDU_BUSY: begin
          if (mdu_cnt == MDU_LAT_W'(1)) begin
            mdu_state <= MDU_IDLE;
            mdu_cnt   <= '0;
          end else begin
            mdu_cnt <= mdu_cnt - 1'b1;
          end
        end
        default: begin
          mdu_state <= MDU_IDLE;
          mdu_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomized and directed bench for hazard_scoreboard_unit against a behavioural model.
module tb_hazard_scoreboard_unit;
  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic [NUM_RD-1:0]       id_rd_use;
  logic [NUM_RD*5-1:0]     id_rd_addr;
  logic [NUM_RD*32-1:0]    wb_rd_data;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_FWD*5-1:0]    fwd_addr;
  logic [NUM_FWD*32-1:0]   fwd_data;
  logic [NUM_FWD-1:0]      fwd_clean;
  logic                    id_use_hilo;
  logic                    mdu_start;
  logic [5:0]              mdu_lat;
  logic                    flush;
  logic [NUM_RD*32-1:0]    rd_data_latest;
  logic                    pc_en;
  logic                    if_id_en;
  logic                    id_ex_clr;
  logic                    mdu_busy;
  logic [CNT_W-1:0]        stall_cnt;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // Model state: cycles of HI/LO occupancy left, and the expected stall count.
  int m_rem = 0;
  int m_cnt = 0;

  hazard_scoreboard_unit #(.NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rd_use      (id_rd_use),
    .id_rd_addr     (id_rd_addr),
    .wb_rd_data     (wb_rd_data),
    .fwd_we         (fwd_we),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data),
    .fwd_clean      (fwd_clean),
    .id_use_hilo    (id_use_hilo),
    .mdu_start      (mdu_start),
    .mdu_lat        (mdu_lat),
    .flush          (flush),
    .rd_data_latest (rd_data_latest),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_clr      (id_ex_clr),
    .mdu_busy       (mdu_busy),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_comb(output logic [NUM_RD*32-1:0] exp_rd, output logic exp_stall);
    logic any_haz;
    logic hilo;
    any_haz = 1'b0;
    exp_rd  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [31:0] d;
      logic [4:0]  a;
      bit found;
      bit clean;
      a     = id_rd_addr[p*5 +: 5];
      d     = wb_rd_data[p*32 +: 32];
      found = 1'b0;
      clean = 1'b1;
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_we[i] && fwd_addr[i*5 +: 5] == a) begin
          found = 1'b1;
          d     = fwd_data[i*32 +: 32];
          clean = fwd_clean[i];
        end
      end
      exp_rd[p*32 +: 32] = d;
      if (id_rd_use[p] && a != 0 && found && !clean) any_haz = 1'b1;
    end
    hilo      = id_use_hilo && (m_rem > 0 || mdu_start);
    exp_stall = (any_haz || hilo) && !flush;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem <= 0;
      m_cnt <= 0;
    end else begin
      logic [NUM_RD*32-1:0] er;
      logic es;
      model_comb(er, es);
      if (PERF && es && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (flush)          m_rem <= 0;
      else if (mdu_start) m_rem <= (mdu_lat == 0) ? 1 : int'(mdu_lat);
      else if (m_rem > 0) m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic [NUM_RD*32-1:0] er;
      logic es;
      model_comb(er, es);
      chk("rd_data_latest", rd_data_latest, er);
      chk("pc_en", pc_en, !es);
      chk("if_id_en", if_id_en, !es);
      chk("id_ex_clr", id_ex_clr, es || flush);
      chk("mdu_busy", mdu_busy, m_rem > 0);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic idle_inputs();
    id_rd_use   = '0;
    id_rd_addr  = '0;
    wb_rd_data  = {32'h1111_0001, 32'h2222_0000};
    fwd_we      = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
    fwd_clean   = '1;
    id_use_hilo = 1'b0;
    mdu_start   = 1'b0;
    mdu_lat     = '0;
    flush       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] a);
    idle_inputs();
    fwd_we         = 2'b01;
    fwd_clean      = 2'b00;
    fwd_addr[4:0]  = a;
    id_rd_use[1]   = 1'b1;
    id_rd_addr[9:5] = a;
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd7;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b1;
    #3;
    chk("reset mdu_busy", mdu_busy, 1'b0);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset pc_en", pc_en, 1'b1);
    chk("reset if_id_en", if_id_en, 1'b1);
    chk("reset id_ex_clr", id_ex_clr, 1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Forwarding priority: EX beats AM on the same address.
    fwd_we    = 2'b11;
    fwd_addr  = {5'd5, 5'd5};
    fwd_data  = {32'h0000_BBBB, 32'h0000_AAAA};
    id_rd_use = 2'b01;
    id_rd_addr = {5'd0, 5'd5};
    #2;
    chk("prio ex wins", rd_data_latest[31:0], 32'h0000_AAAA);
    chk("prio no stall", pc_en, 1'b1);
    fwd_we = 2'b10;
    #1;
    chk("prio am only", rd_data_latest[31:0], 32'h0000_BBBB);
    next_cycle();

    load_use(5'd7);
    #2;
    chk("load-use pc_en", pc_en, 1'b0);
    chk("load-use id_ex_clr", id_ex_clr, 1'b1);
    repeat (3) next_cycle();
    #2;
    chk("load-use stall_cnt", stall_cnt, PERF ? 3 : 0);
    flush = 1'b1;
    #1;
    chk("flush gates stall", pc_en, 1'b1);
    chk("flush clears id_ex", id_ex_clr, 1'b1);
    next_cycle();

    load_use(5'd0);
    #2;
    chk("addr0 no stall", pc_en, 1'b1);
    next_cycle();

    idle_inputs();
    id_use_hilo = 1'b1;
    mdu_start   = 1'b1;
    mdu_lat     = 6'd3;
    #2;
    chk("hilo start stall", pc_en, 1'b0);
    chk("busy before edge", mdu_busy, 1'b0);
    next_cycle();
    mdu_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("countdown busy", mdu_busy, 1'b1);
      chk("countdown stall", pc_en, 1'b0);
      next_cycle();
    end
    #2;
    chk("countdown done", mdu_busy, 1'b0);
    chk("countdown release", pc_en, 1'b1);
    next_cycle();

    idle_inputs();
    mdu_start = 1'b1;
    mdu_lat   = 6'd10;
    next_cycle();
    mdu_start = 1'b0;
    flush     = 1'b1;
    #2;
    chk("busy before flush", mdu_busy, 1'b1);
    next_cycle();
    flush = 1'b0;
    #2;
    chk("flush idles", mdu_busy, 1'b0);
    next_cycle();

    mdu_start = 1'b1;
    mdu_lat   = 6'd10;
    next_cycle();
    mdu_start = 1'b0;
    #2;
    chk("busy before rst", mdu_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst busy", mdu_busy, 1'b0);
    chk("async rst stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    next_cycle();

    load_use(5'd9);
    repeat (20) next_cycle();
    #2;
    chk("saturated stall_cnt", stall_cnt, PERF ? 15 : 0);
    next_cycle();

    idle_inputs();
    mdu_start = 1'b1;
    mdu_lat   = 6'd0;
    next_cycle();
    mdu_start = 1'b0;
    #2;
    chk("lat0 busy", mdu_busy, 1'b1);
    next_cycle();
    #2;
    chk("lat0 done", mdu_busy, 1'b0);

    mdu_start = 1'b1;
    mdu_lat   = 6'd2;
    next_cycle();
    mdu_lat   = 6'd4;
    next_cycle();
    mdu_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("reload busy", mdu_busy, 1'b1);
      next_cycle();
    end
    #2;
    chk("reload done", mdu_busy, 1'b0);

    mdu_start = 1'b1;
    flush     = 1'b1;
    mdu_lat   = 6'd5;
    next_cycle();
    idle_inputs();
    #2;
    chk("flush beats start", mdu_busy, 1'b0);
    next_cycle();

    for (int n = 0; n < 3000; n++) begin
      id_rd_use   = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++) begin
        id_rd_addr[p*5 +: 5]  = pick_addr();
        wb_rd_data[p*32 +: 32] = $urandom;
      end
      for (int i = 0; i < NUM_FWD; i++) begin
        fwd_addr[i*5 +: 5]  = pick_addr();
        fwd_data[i*32 +: 32] = $urandom;
      end
      fwd_we      = NUM_FWD'($urandom);
      fwd_clean   = NUM_FWD'($urandom) | NUM_FWD'($urandom);
      id_use_hilo = ($urandom_range(0, 2) == 0);
      mdu_start   = ($urandom_range(0, 7) == 0);
      mdu_lat     = 6'($urandom_range(0, 6));
      flush       = ($urandom_range(0, 15) == 0);
      next_cycle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
